// File: rtl/fp32_pkg.sv
// Shared binary32 field widths, special encodings and the unpacked operand view
// used by the FP_32 arithmetic cluster.
package fp32_pkg;

   localparam int EXP_W  = 8;
   localparam int FRAC_W = 23;
   localparam int BIAS   = 127;

   localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
   localparam logic [31:0] FP32_PINF = 32'h7F80_0000;
   localparam logic [31:0] FP32_NINF = 32'hFF80_0000;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
   } fp32_t;

endpackage

// File: rtl/fp_lzc28.sv
// Leading-zero counter over the 28-bit pre-normalised significand
// (carry, 24-bit significand, guard/round/sticky). An all-zero input reports 28.
module fp_lzc28 (
   input  logic [27:0] value,
   output logic [4:0]  count
);

   // Scanning upward lets the highest set bit win.
   always_comb begin
      count = 5'd28;
      for (int i = 0; i < 28; i++) begin
         if (value[i]) count = 5'(27 - i);
      end
   end

endmodule

// File: rtl/fp_32_add_or_sub.sv
// Binary32 adder/subtractor: combinational align/add/normalise/round datapath
// into a single result register (one operation per cycle, 1-cycle latency).
module fp_32_add_or_sub
   import fp32_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] add1,
   input  logic [31:0] add2,
   input  logic        command,
   output logic [31:0] result
);

   fp32_t       a, b, x, y;
   logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   logic        swap;
   logic [7:0]  exp_diff;
   logic [49:0] shifted;
   logic [26:0] x_al, y_al;
   logic [27:0] sum;
   logic [4:0]  lzc;
   logic [27:0] norm;
   logic        round_up;
   logic [24:0] mant;
   logic [9:0]  exp_n, exp_r;
   logic [22:0] frac_r;
   logic [31:0] next_result;

   // Unpack with denormals flushed, B's sign already carrying the operation,
   // then order by magnitude and align the smaller operand with guard/round/sticky.
   always_comb begin
      a        = add1;
      b        = add2;
      b.sign   = add2[31] ^ ~command;
      a_nan    = (&add1[30:23]) && (|add1[22:0]);
      b_nan    = (&add2[30:23]) && (|add2[22:0]);
      a_inf    = (&add1[30:23]) && !(|add1[22:0]);
      b_inf    = (&add2[30:23]) && !(|add2[22:0]);
      a_zero   = !(|add1[30:23]);
      b_zero   = !(|add2[30:23]);
      if (a_zero) a.frac = '0;
      if (b_zero) b.frac = '0;
      swap     = {b.exp, b.frac} > {a.exp, a.frac};
      x        = swap ? b : a;
      y        = swap ? a : b;
      exp_diff = x.exp - y.exp;
      shifted  = {1'b1, y.frac, 26'b0} >> exp_diff;
      x_al     = {1'b1, x.frac, 3'b000};
      if (exp_diff > 8'd26) y_al = 27'd1;
      else                  y_al = {shifted[49:24], |shifted[23:0]};
      if (x.sign ^ y.sign) sum = {1'b0, x_al} - {1'b0, y_al};
      else                 sum = {1'b0, x_al} + {1'b0, y_al};
   end

   fp_lzc28 u_lzc (
      .value (sum),
      .count (lzc)
   );

   // Normalising to bit 27 covers both the carry-out case (lzc=0) and cancellation;
   // exponent arithmetic is 10-bit so a negative result shows up in bit 9.
   always_comb begin
      norm     = sum << lzc;
      exp_n    = {2'b00, x.exp} + 10'd1 - {5'b0, lzc};
      round_up = norm[3] & (norm[2] | norm[1] | norm[0] | norm[4]);
      mant     = {1'b0, norm[27:4]} + {24'b0, round_up};
      exp_r    = exp_n + {9'b0, mant[24]};
      frac_r   = mant[24] ? mant[23:1] : mant[22:0];
      next_result = {x.sign, exp_r[7:0], frac_r};
      if (a_nan || b_nan)
         next_result = FP32_QNAN;
      else if (a_inf && b_inf && (a.sign != b.sign))
         next_result = FP32_QNAN;
      else if (a_inf)
         next_result = a.sign ? FP32_NINF : FP32_PINF;
      else if (b_inf)
         next_result = b.sign ? FP32_NINF : FP32_PINF;
      else if (a_zero && b_zero)
         next_result = {a.sign & b.sign, 31'b0};
      else if (a_zero)
         next_result = b;
      else if (b_zero)
         next_result = a;
      else if (sum == 28'd0)
         next_result = 32'h0000_0000;
      else if (exp_n[9] || (exp_n == 10'd0))
         next_result = {x.sign, 31'b0};
      else if (exp_r >= 10'd255)
         next_result = x.sign ? FP32_NINF : FP32_PINF;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) result <= 32'h0000_0000;
      else      result <= next_result;
   end

endmodule

// File: tb/tb_fp_32_add_or_sub.sv
// Directed bench for fp_32_add_or_sub: expected results are queued as stimulus
// is driven and popped one cycle later when the registered result appears.
module tb_fp_32_add_or_sub;

   logic        clk;
   logic        rst;
   logic [31:0] add1;
   logic [31:0] add2;
   logic        command;
   logic [31:0] result;

   logic [31:0] exp_q[$];
   string       tag_q[$];
   int          checks = 0;
   int          errors = 0;

   fp_32_add_or_sub dut (
      .clk     (clk),
      .rst     (rst),
      .add1    (add1),
      .add2    (add2),
      .command (command),
      .result  (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput();
      logic [31:0] want;
      string       tag;
      want = exp_q.pop_front();
      tag  = tag_q.pop_front();
      checks++;
      assert (result === want)
      else begin
         errors++;
         $error("[TB] FAIL %s got %h want %h", tag, result, want);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                input logic cmd, input logic [31:0] want,
                                input string tag);
      add1    = a;
      add2    = b;
      command = cmd;
      exp_q.push_back(want);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   initial begin
      rst     = 1'b1;
      add1    = 32'h4080_0000;
      add2    = 32'h4000_0000;
      command = 1'b1;
      #1 rst  = 1'b0;
      #2;
      checks++;
      assert (result === 32'h0000_0000)
      else begin
         errors++;
         $error("[TB] FAIL reset_init got %h want %h", result, 32'h0000_0000);
      end
      @(negedge clk);
      rst = 1'b1;

      applyStimulus(32'h4080_0000, 32'h4000_0000, 1'b0, 32'h4000_0000, "sub_4_2");
      applyStimulus(32'h4080_0000, 32'h4000_0000, 1'b1, 32'h40C0_0000, "add_4_2");
      applyStimulus(32'h3FC0_0001, 32'h3FC0_2000, 1'b1, 32'h4040_1000, "tie_carry");
      applyStimulus(32'h41F0_0000, 32'h41A0_0000, 1'b0, 32'h4120_0000, "cancel_30_20");
      applyStimulus(32'h42BA_98BA, 32'h42BA_98BA, 1'b0, 32'h0000_0000, "x_minus_x");
      applyStimulus(32'h4800_4ABC, 32'h4200_98BA, 1'b1, 32'h4800_52C6, "gap_add");
      applyStimulus(32'h4800_4ABC, 32'hC2BA_98BA, 1'b0, 32'h4800_620F, "gap_sub_neg");
      applyStimulus(32'h7F80_0000, 32'h7F80_0000, 1'b0, 32'h7FC0_0000, "inf_minus_inf");
      applyStimulus(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b1, 32'h7F80_0000, "overflow");
      applyStimulus(32'h7FA0_0000, 32'h3F80_0000, 1'b1, 32'h7FC0_0000, "nan_in");
      applyStimulus(32'h0000_0001, 32'h3F80_0000, 1'b1, 32'h3F80_0000, "denorm_flush");
      applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b1, 32'h8000_0000, "negz_plus_negz");
      applyStimulus(32'h8000_0000, 32'h0000_0000, 1'b0, 32'h8000_0000, "negz_minus_z");
      applyStimulus(32'h0000_0000, 32'h3F80_0000, 1'b0, 32'hBF80_0000, "zero_minus_one");
      applyStimulus(32'h3F80_0000, 32'h7F80_0000, 1'b0, 32'hFF80_0000, "one_minus_inf");
      applyStimulus(32'h0080_0000, 32'h0080_0001, 1'b0, 32'h8000_0000, "underflow");
      applyStimulus(32'h3F80_0000, 32'h3380_0000, 1'b1, 32'h3F80_0000, "tie_even_down");
      applyStimulus(32'h3F80_0000, 32'h3380_0001, 1'b1, 32'h3F80_0001, "sticky_round_up");

      add1    = 32'h4120_0000;
      add2    = 32'h3F80_0000;
      command = 1'b1;
      #2 rst  = 1'b0;
      #1;
      checks++;
      assert (result === 32'h0000_0000)
      else begin
         errors++;
         $error("[TB] FAIL reset_mid got %h want %h", result, 32'h0000_0000);
      end
      @(negedge clk);
      rst = 1'b1;
      applyStimulus(32'h4120_0000, 32'h3F80_0000, 1'b0, 32'h4110_0000, "after_reset");
      applyStimulus(32'hC040_0000, 32'h3F80_0000, 1'b1, 32'hC000_0000, "neg_plus_pos");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fp_32_add_or_sub.md
Name: fp_32_add_or_sub

Overview:
- Single-precision IEEE-754 adder/subtractor with a registered result.
- Computes add1 + add2 when command=1 and add1 - add2 when command=0.
- Combinational datapath feeds one output register; 1-cycle latency, fully pipelined: one new operation accepted every cycle.
- Used as the FP add/sub leaf in the FP_32 arithmetic cluster.

Parameters:
- None. Format is fixed at binary32: 1 sign bit, 8 exponent bits, 23 fraction bits, bias 127.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- add1  input  32  operand A, IEEE-754 binary32.
- add2  input  32  operand B, IEEE-754 binary32.
- command  input  1  1 = add (A+B); 0 = subtract (A-B).
- result  output  32  registered IEEE-754 binary32 result.

Behaviour:
- Reset: rst low forces result = 32'h0000_0000 immediately, without waiting for a clock edge. Reset is released synchronously to clk.
- Latency: the result register captures f(add1, add2, command) on every rising clk edge while rst is high. Result is visible after that edge, so latency is 1 cycle. There is no handshake and no enable.
- Reset mid-operation: the in-flight result is discarded. The first valid result is produced at the first edge after rst deasserts.
- Subtraction: invert the sign of B, then perform a signed-magnitude add.
- Denormal inputs (exp=0, frac≠0) are flushed to signed zero before use.
- Datapath:
  1. Unpack each operand and insert the hidden 1.
  2. Swap so the larger magnitude is operand X.
  3. Align Y by shifting right by the exponent difference (0..255). Keep guard, round and sticky bits; sticky is the OR of all bits shifted out.
  4. Same effective sign: add the significands. On carry-out, shift right 1 and increment the exponent.
  5. Different effective sign: subtract (X-Y). Normalise left using a leading-zero count; exponent -= lzc.
  6. Rounding is round-to-nearest-even on guard/round/sticky. A carry out of rounding renormalises and increments the exponent.
  7. Result sign = sign of X.
- Exact zero: an exact zero difference yields +0. (-0)+(-0), or -0 - (+0), yields -0.
- Overflow: exponent ≥ 255 after rounding yields ±Inf (exp=8'hFF, frac=0).
- Underflow: exponent ≤ 0 after normalisation flushes to ±0; denormals are never produced.
- Specials, in priority order:
  1. Any NaN input gives canonical NaN 32'h7FC0_0000.
  2. Inf + (-Inf) under the effective operation gives 32'h7FC0_0000.
  3. One Inf operand gives that Inf, with the effective sign.
  4. Zero operand: return the other operand, with effective sign for B.
- No exception flags are produced.

Decomposition:
- Package fp32_pkg holds:
  - field widths: EXP_W=8, FRAC_W=23;
  - BIAS=127;
  - constants FP32_QNAN=32'h7FC0_0000, FP32_PINF=32'h7F80_0000, FP32_NINF=32'hFF80_0000;
  - packed struct fp32_t {sign, exp, frac}.
- One sub-module, fp_lzc28: a leading-zero counter over the 28-bit pre-normalised significand (24 + carry/guard/round/sticky). Everything else stays in fp_32_add_or_sub.

Test Plan:
- Reset: rst=0 with nonzero inputs -> result=32'h00000000 asynchronously. After release, the first edge loads the computed value.
- 4.0 - 2.0: add1=32'h40800000, add2=32'h40000000, command=0 -> result=32'h40000000 one cycle later. Then command=1 -> 32'h40C00000 (6.0).
- Tie rounding: add1=32'h3FC00001, add2=32'h3FC02000, command=1 -> 32'h40401000 (carry shift with guard=1, sticky=0, ties to even).
- Cancellation: 30.0 - 20.0 (32'h41F00000, 32'h41A00000, command=0) -> 32'h41200000. Also x - x for add1=add2=32'h42BA98BA -> 32'h00000000 (+0).
- Large exponent gap: 32'h48004ABC + 32'h420098BA and 32'h48004ABC - 32'hC2BA98BA (command=0) -> match the bit-exact RNE reference model. The second case behaves as an addition.
- Specials:
  - 32'h7F800000 - 32'h7F800000 -> 32'h7FC00000.
  - 32'h7F7FFFFF + 32'h7F7FFFFF -> 32'h7F800000.
  - NaN input 32'h7FA00000 -> 32'h7FC00000.
  - Denormal 32'h00000001 + 32'h3F800000 -> 32'h3F800000.
